// File: rtl/decode_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : decode_rf_scoreboard
//  Purpose  : Decode-stage register file with same-cycle write-to-read bypass
//             and a per-register pending-write scoreboard. It stalls decode on
//             RAW hazards against writes still in flight, and on counter
//             saturation.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             rd1_*/rd2_*       - two read ports (select, enable, data out)
//             issue_*           - instruction leaving decode (valid/wr/dst)
//             wb_*              - writeback port (valid/select/data)
//             stall             - decode must hold, issue not accepted
//             err               - sticky scoreboard-underflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module decode_rf_scoreboard #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = $clog2(NREGS),
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd1_sel,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd2_sel,
    input  logic              rd2_en,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              err
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic              err_q;
    logic              err_d;

    logic              wb_hit1;
    logic              wb_hit2;
    logic              haz1;
    logic              haz2;
    logic              sat;
    logic              acc_wr;
    logic [NREGS-1:0]  inc;
    logic [NREGS-1:0]  dec;

    // ------------------------------------------------------------------
    // Read ports: writeback data is forwarded in the same cycle.
    // ------------------------------------------------------------------
    assign wb_hit1  = wb_valid && (wb_sel == rd1_sel);
    assign wb_hit2  = wb_valid && (wb_sel == rd2_sel);
    assign rd1_data = wb_hit1 ? wb_data : regs_q[rd1_sel];
    assign rd2_data = wb_hit2 ? wb_data : regs_q[rd2_sel];

    // ------------------------------------------------------------------
    // Hazard detection. The enable is evaluated first so that an unused
    // select (possibly X) cannot influence stall. A same-cycle writeback
    // only resolves the hazard when it retires the last outstanding write;
    // with more in flight, the forwarded value is not the one the reader
    // needs.
    // ------------------------------------------------------------------
    assign haz1 = rd1_en && (pend_q[rd1_sel] != PEND_ZERO)
                  && !(wb_hit1 && (pend_q[rd1_sel] == PEND_ONE));
    assign haz2 = rd2_en && (pend_q[rd2_sel] != PEND_ZERO)
                  && !(wb_hit2 && (pend_q[rd2_sel] == PEND_ONE));

    // Saturation ignores any same-cycle writeback, so a counter can never
    // overflow even if that writeback turns out to be spurious.
    assign sat    = issue_valid && issue_wr && (pend_q[issue_dst] == PEND_MAX);
    assign stall  = issue_valid && (haz1 || haz2 || sat);
    assign acc_wr = issue_valid && !stall && issue_wr;
    assign err    = err_q;

    // ------------------------------------------------------------------
    // Next-state: register writes and pending-counter updates. The hazard
    // check above used the current counters, so an instruction reading its
    // own destination is checked before its own increment lands.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        err_d  = err_q;
        inc    = '0;
        dec    = '0;

        if (wb_valid) begin
            regs_d[wb_sel] = wb_data;
        end

        for (int i = 0; i < NREGS; i++) begin
            inc[i] = acc_wr   && (issue_dst == ADDR_W'(i));
            dec[i] = wb_valid && (wb_sel    == ADDR_W'(i));
            if (inc[i] && !dec[i]) begin
                pend_d[i] = pend_q[i] + PEND_ONE;
            end else if (dec[i] && !inc[i]) begin
                // Writeback with nothing outstanding: keep the counter at
                // zero and flag it, the data write above still happens.
                if (pend_q[i] == PEND_ZERO) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] - PEND_ONE;
                end
            end
        end
    end

    // Reset dominates any concurrent issue or writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
                pend_q[i] <= pend_d[i];
            end
            err_q <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_rf_scoreboard
//  Purpose  : Self-checking bench for decode_rf_scoreboard. Instance A uses
//             the default 16-bit x 8-register configuration driven from a
//             vector table; instance B uses 32-bit x 16 registers for the
//             wide-data and reset-during-hazard sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_rf_scoreboard;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: 16 x 8 ----------------
    logic        a_rst;
    logic [2:0]  a_rd1_sel, a_rd2_sel, a_issue_dst, a_wb_sel;
    logic        a_rd1_en, a_rd2_en, a_issue_valid, a_issue_wr, a_wb_valid;
    logic [15:0] a_wb_data, a_rd1_data, a_rd2_data;
    logic        a_stall, a_err;

    decode_rf_scoreboard #(.DATA_W(16), .NREGS(8), .ADDR_W(3), .PEND_W(2)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .rd1_sel(a_rd1_sel), .rd1_en(a_rd1_en),
        .rd2_sel(a_rd2_sel), .rd2_en(a_rd2_en),
        .rd1_data(a_rd1_data), .rd2_data(a_rd2_data),
        .issue_valid(a_issue_valid), .issue_wr(a_issue_wr), .issue_dst(a_issue_dst),
        .wb_valid(a_wb_valid), .wb_sel(a_wb_sel), .wb_data(a_wb_data),
        .stall(a_stall), .err(a_err)
    );

    // ---------------- instance B: 32 x 16 ----------------
    logic        b_rst;
    logic [3:0]  b_rd1_sel, b_rd2_sel, b_issue_dst, b_wb_sel;
    logic        b_rd1_en, b_rd2_en, b_issue_valid, b_issue_wr, b_wb_valid;
    logic [31:0] b_wb_data, b_rd1_data, b_rd2_data;
    logic        b_stall, b_err;

    decode_rf_scoreboard #(.DATA_W(32), .NREGS(16), .ADDR_W(4), .PEND_W(2)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .rd1_sel(b_rd1_sel), .rd1_en(b_rd1_en),
        .rd2_sel(b_rd2_sel), .rd2_en(b_rd2_en),
        .rd1_data(b_rd1_data), .rd2_data(b_rd2_data),
        .issue_valid(b_issue_valid), .issue_wr(b_issue_wr), .issue_dst(b_issue_dst),
        .wb_valid(b_wb_valid), .wb_sel(b_wb_sel), .wb_data(b_wb_data),
        .stall(b_stall), .err(b_err)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  r1s;
        logic        r1e;
        logic [2:0]  r2s;
        logic        r2e;
        logic        iv;
        logic        iw;
        logic [2:0]  dst;
        logic        wv;
        logic [2:0]  ws;
        logic [15:0] wd;
        logic        e_stall;
        logic [15:0] e_r1;
        logic [15:0] e_r2;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic [2:0] r1s, input logic r1e, input logic [2:0] r2s, input logic r2e,
        input logic iv, input logic iw, input logic [2:0] dst,
        input logic wv, input logic [2:0] ws, input logic [15:0] wd,
        input logic es, input logic [15:0] er1, input logic [15:0] er2, input logic ee);
        vec_t v;
        v.r1s = r1s; v.r1e = r1e; v.r2s = r2s; v.r2e = r2e;
        v.iv = iv; v.iw = iw; v.dst = dst;
        v.wv = wv; v.ws = ws; v.wd = wd;
        v.e_stall = es; v.e_r1 = er1; v.e_r2 = er2; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_a(input vec_t v);
        a_rd1_sel = v.r1s; a_rd1_en = v.r1e;
        a_rd2_sel = v.r2s; a_rd2_en = v.r2e;
        a_issue_valid = v.iv; a_issue_wr = v.iw; a_issue_dst = v.dst;
        a_wb_valid = v.wv; a_wb_sel = v.ws; a_wb_data = v.wd;
    endtask

    task automatic idle_b();
        b_rd1_sel = '0; b_rd1_en = 1'b0; b_rd2_sel = '0; b_rd2_en = 1'b0;
        b_issue_valid = 1'b0; b_issue_wr = 1'b0; b_issue_dst = '0;
        b_wb_valid = 1'b0; b_wb_sel = '0; b_wb_data = '0;
    endtask

    initial begin
        // Each row is one cycle: outputs checked mid-cycle, then a clock edge.
        tbl[0]  = mk(0,0,0,0, 1,1,3, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // issue wr r3
        tbl[1]  = mk(3,1,0,0, 1,0,0, 0,0,16'h0000, 1,16'h0000,16'h0000,0); // read r3 -> stall
        tbl[2]  = mk(3,1,0,0, 1,0,0, 0,0,16'h0000, 1,16'h0000,16'h0000,0); // still held
        tbl[3]  = mk(3,1,0,0, 1,0,0, 1,3,16'hBEEF, 0,16'hBEEF,16'h0000,0); // wb releases, bypass
        tbl[4]  = mk(3,1,3,1, 1,0,0, 0,0,16'h0000, 0,16'hBEEF,16'hBEEF,0); // array path
        tbl[5]  = mk(0,0,0,0, 1,1,5, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // issue r5 #1
        tbl[6]  = mk(0,0,0,0, 1,1,5, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // issue r5 #2
        tbl[7]  = mk(0,0,5,1, 1,0,0, 1,5,16'h1111, 1,16'h0000,16'h1111,0); // 1st wb, still stalled
        tbl[8]  = mk(0,0,5,1, 1,0,0, 1,5,16'h2222, 0,16'h0000,16'h2222,0); // 2nd wb releases
        tbl[9]  = mk(0,0,0,0, 1,1,2, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // r2 pend 1
        tbl[10] = mk(0,0,0,0, 1,1,2, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // r2 pend 2
        tbl[11] = mk(0,0,0,0, 1,1,2, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // r2 pend 3
        tbl[12] = mk(0,0,0,0, 1,1,2, 0,0,16'h0000, 1,16'h0000,16'h0000,0); // saturated
        tbl[13] = mk(0,0,2,0, 1,1,2, 1,2,16'h0AAA, 1,16'h0000,16'h0AAA,0); // sat holds, wb -> pend 2
        tbl[14] = mk(0,0,2,0, 1,1,2, 1,2,16'h0BBB, 0,16'h0000,16'h0BBB,0); // inc+dec -> pend 2
        tbl[15] = mk(0,0,0,0, 1,1,2, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // pend 3
        tbl[16] = mk(0,0,0,0, 1,1,2, 0,0,16'h0000, 1,16'h0000,16'h0000,0); // saturated again
        tbl[17] = mk(1,1,0,1, 1,1,1, 0,0,16'h0000, 0,16'h0000,16'h0000,0); // add r1,r1,r0
        tbl[18] = mk(1,1,0,0, 1,0,0, 0,0,16'h0000, 1,16'h0000,16'h0000,0); // later reader of r1
        tbl[19] = mk(1,0,2,0, 1,0,0, 0,0,16'h0000, 0,16'h0000,16'h0BBB,0); // disabled ports
        tbl[20] = mk(0,0,0,0, 0,0,0, 1,4,16'h4444, 0,16'h0000,16'h0000,0); // underflow wb r4
        tbl[21] = mk(4,1,0,0, 0,0,0, 0,0,16'h0000, 0,16'h4444,16'h0000,1); // err sticky, data written
        tbl[22] = mk(4,1,0,0, 1,0,0, 0,0,16'h0000, 0,16'h4444,16'h0000,1); // r4 no hazard
        tbl[23] = mk(1,1,0,0, 0,0,0, 0,0,16'h0000, 0,16'h0000,16'h0000,1); // no issue -> no stall
        tbl[24] = mk(0,0,2,1, 1,0,0, 1,2,16'h0CCC, 1,16'h0000,16'h0CCC,1); // pend3 wb: still stalled

        // ---------------- reset ----------------
        a_rst = 1'b1; b_rst = 1'b1;
        apply_a(mk(0,0,0,0, 0,0,0, 0,0,16'h0, 0,16'h0,16'h0,0));
        idle_b();
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state: every register reads zero, no stall, no error.
        for (int r = 0; r < 8; r++) begin
            a_rd1_sel = 3'(r); a_rd2_sel = 3'(7 - r);
            a_rd1_en = 1'b1; a_rd2_en = 1'b1; a_issue_valid = 1'b1;
            #1;
            chk($sformatf("reset rd1 r%0d", r), 32'(a_rd1_data), 32'h0);
            chk($sformatf("reset rd2 r%0d", 7 - r), 32'(a_rd2_data), 32'h0);
            chk($sformatf("reset stall r%0d", r), 32'(a_stall), 32'h0);
            tick();
        end
        chk("reset err", 32'(a_err), 32'h0);

        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) begin
            apply_a(tbl[i]);
            #1;
            chk($sformatf("row%0d stall", i), 32'(a_stall), 32'(tbl[i].e_stall));
            chk($sformatf("row%0d rd1", i), 32'(a_rd1_data), 32'(tbl[i].e_r1));
            chk($sformatf("row%0d rd2", i), 32'(a_rd2_data), 32'(tbl[i].e_r2));
            chk($sformatf("row%0d err", i), 32'(a_err), 32'(tbl[i].e_err));
            tick();
        end

        // ---------------- A: reset in the middle of a hazard ----------------
        // r1 still has one write pending; rst lands with a concurrent issue and wb.
        apply_a(mk(1,1,0,0, 1,1,6, 1,3,16'h7777, 0,16'h0,16'h0,0));
        a_rst = 1'b1;
        #1;
        chk("a rst-cycle stall", 32'(a_stall), 32'h1);
        tick();
        a_rst = 1'b0;
        apply_a(mk(1,1,3,1, 1,0,0, 0,0,16'h0, 0,16'h0,16'h0,0));
        #1;
        chk("a post-rst stall", 32'(a_stall), 32'h0);
        chk("a post-rst r1", 32'(a_rd1_data), 32'h0);
        chk("a post-rst r3", 32'(a_rd2_data), 32'h0);
        chk("a post-rst err", 32'(a_err), 32'h0);
        tick();
        apply_a(mk(6,1,4,1, 1,0,0, 0,0,16'h0, 0,16'h0,16'h0,0));
        #1;
        chk("a rst dropped issue r6", 32'(a_stall), 32'h0);
        chk("a rst cleared r4", 32'(a_rd2_data), 32'h0);
        tick();
        // Stale writeback after reset hits a zero counter.
        apply_a(mk(0,0,0,0, 0,0,0, 1,1,16'h5555, 0,16'h0,16'h0,0));
        tick();
        apply_a(mk(1,1,0,0, 0,0,0, 0,0,16'h0, 0,16'h0,16'h0,0));
        #1;
        chk("a stale wb err", 32'(a_err), 32'h1);
        chk("a stale wb data", 32'(a_rd1_data), 32'h5555);
        tick();

        // ---------------- B: wide configuration ----------------
        b_wb_valid = 1'b1; b_wb_sel = 4'd15; b_wb_data = 32'hDEAD_BEEF;
        b_rd1_sel = 4'd15; b_rd1_en = 1'b1;
        #1;
        chk("b bypass r15", b_rd1_data, 32'hDEAD_BEEF);
        chk("b bypass stall", 32'(b_stall), 32'h0);
        tick();
        idle_b();
        b_rd1_sel = 4'd15; b_rd1_en = 1'b1; b_rd2_sel = 4'd15; b_rd2_en = 1'b1;
        #1;
        chk("b array r15 rd1", b_rd1_data, 32'hDEAD_BEEF);
        chk("b array r15 rd2", b_rd2_data, 32'hDEAD_BEEF);
        chk("b underflow err", 32'(b_err), 32'h1);
        tick();
        // Clear err, then set up a hazard on r9 and reset while it stalls.
        idle_b(); b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        b_issue_valid = 1'b1; b_issue_wr = 1'b1; b_issue_dst = 4'd9;
        #1;
        chk("b err cleared", 32'(b_err), 32'h0);
        tick();
        idle_b();
        b_issue_valid = 1'b1; b_rd1_sel = 4'd9; b_rd1_en = 1'b1;
        #1;
        chk("b hazard r9", 32'(b_stall), 32'h1);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        b_rd2_sel = 4'd15; b_rd2_en = 1'b1;
        #1;
        chk("b post-rst stall", 32'(b_stall), 32'h0);
        chk("b post-rst r15", b_rd2_data, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the directed sequence is short, so this should never fire.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
